// File: rtl/rf_debug_pkg.sv
// Shared types and constants for the register-file debug port.
package rf_debug_pkg;

  localparam int RF_DEPTH = 32;

  // Index of the final beat of a dump for a given address width.
  function automatic int last_idx(input int aw);
    return (1 << aw) - 1;
  endfunction

  localparam int DUMP_LAST_IDX = last_idx($clog2(RF_DEPTH));

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP,
    ST_DUMP_RD,
    ST_DUMP_RSP
  } dbg_state_e;

endpackage

// File: rtl/rf_debug_rsp_reg.sv
// Response holding register: captures addr/data(/err) on load, holds until the host takes it.
// Optional error flag built when RF_DEBUG_PORT_ERR_EN is defined.
module rf_debug_rsp_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
`ifdef RF_DEBUG_PORT_ERR_EN
  input  logic              err_i,
  output logic              err_o,
`endif
  input  logic              ready_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      addr_q  <= addr_i;
      data_q  <= data_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

`ifdef RF_DEBUG_PORT_ERR_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst)         err_q <= 1'b0;
    else if (load_i) err_q <= err_i;
  end
  assign err_o = err_q;
`endif

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;

endmodule

// File: rtl/rf_debug_port.sv
// Debug-host access unit for the register file: single read/write requests plus a full dump.
// Define RF_DEBUG_PORT_ERR_EN to add rsp_err, flagging acks of writes to x0.
module rf_debug_port
  import rf_debug_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_halted,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              dump_start,
  output logic              dump_busy,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_rdata,
`ifdef RF_DEBUG_PORT_ERR_EN
  output logic              rsp_err,
`endif
  output logic [ADDR_W-1:0] rf_ra,
  input  logic [DATA_W-1:0] rf_rd,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic              rf_we
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(last_idx(ADDR_W));

  dbg_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              accept;
  logic              addr_is_x0;
  logic              ld;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;

  assign accept     = req_valid && req_ready;
  assign addr_is_x0 = (addr_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (dump_start && core_halted) begin
          state_d = ST_DUMP_RD;
          cnt_d   = '0;
        end else if (accept) begin
          state_d = req_we ? ST_WRITE : ST_READ;
        end
      end
      ST_READ:  state_d = ST_RESP;
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      ST_DUMP_RD: state_d = ST_DUMP_RSP;
      ST_DUMP_RSP: begin
        if (rsp_ready) begin
          if (cnt_q == LAST_IDX) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DUMP_RD;
            cnt_d   = cnt_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // rst gates rf_we so a write in flight is dropped on the reset edge.
  always_comb begin
    req_ready = (state_q == ST_IDLE) && core_halted && !dump_start && !rst;
    dump_busy = (state_q == ST_DUMP_RD) || (state_q == ST_DUMP_RSP);
    rf_ra     = '0;
    rf_wa     = '0;
    rf_wd     = '0;
    rf_we     = 1'b0;
    ld        = 1'b0;
    ld_addr   = addr_q;
    ld_data   = '0;
    case (state_q)
      ST_READ: begin
        rf_ra   = addr_q;
        ld      = 1'b1;
        ld_data = rf_rd;
      end
      ST_WRITE: begin
        rf_wa = addr_q;
        rf_wd = wdata_q;
        rf_we = !addr_is_x0 && !rst;
        ld    = 1'b1;
      end
      ST_DUMP_RD: begin
        rf_ra   = cnt_q;
        ld      = 1'b1;
        ld_addr = cnt_q;
        ld_data = rf_rd;
      end
      default: ;
    endcase
  end

  rf_debug_rsp_reg #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rsp (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ld),
    .addr_i  (ld_addr),
    .data_i  (ld_data),
`ifdef RF_DEBUG_PORT_ERR_EN
    .err_i   ((state_q == ST_WRITE) && addr_is_x0),
    .err_o   (rsp_err),
`endif
    .ready_i (rsp_ready),
    .valid_o (rsp_valid),
    .addr_o  (rsp_addr),
    .data_o  (rsp_rdata)
  );

endmodule

// File: tb/tb_rf_debug_port.sv
// Directed bench for rf_debug_port with a behavioural 32x32 register file (x0 reads zero).
module tb_rf_debug_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_halted;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic        dump_start;
  logic        dump_busy;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_addr;
  logic [31:0] rsp_rdata;
`ifdef RF_DEBUG_PORT_ERR_EN
  logic        rsp_err;
`endif
  logic [4:0]  rf_ra;
  logic [31:0] rf_rd;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        rf_we;

  int n_vec = 0;
  int n_err = 0;
  int we_cnt = 0;
  logic [4:0]  last_wa = '0;
  logic [31:0] last_wd = '0;
  logic [31:0] rf_mem [32];

  always #5 clk = ~clk;

  rf_debug_port #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .core_halted (core_halted),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .dump_start  (dump_start),
    .dump_busy   (dump_busy),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_addr    (rsp_addr),
    .rsp_rdata   (rsp_rdata),
`ifdef RF_DEBUG_PORT_ERR_EN
    .rsp_err     (rsp_err),
`endif
    .rf_ra       (rf_ra),
    .rf_rd       (rf_rd),
    .rf_wa       (rf_wa),
    .rf_wd       (rf_wd),
    .rf_we       (rf_we)
  );

  assign rf_rd = (rf_ra == 5'd0) ? 32'd0 : rf_mem[rf_ra];

  always @(posedge clk) if (rf_we) rf_mem[rf_wa] = rf_wd;

  always @(negedge clk) begin
    if (rf_we) begin
      we_cnt  = we_cnt + 1;
      last_wa = rf_wa;
      last_wd = rf_wd;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single request with rsp_ready held high; checks the N / N+1 / N+2 timing.
  task automatic xfer(input logic we, input logic [4:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input string tag);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; rsp_ready = 1'b1;
    #1 chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    #1 chk({tag, "_valid_n"}, 32'(rsp_valid), 32'd0);
    tick();
    chk({tag, "_valid_n1"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_addr"}, 32'(rsp_addr), 32'(a));
    chk({tag, "_rdata"}, rsp_rdata, exp_rd);
`ifdef RF_DEBUG_PORT_ERR_EN
    chk({tag, "_err"}, 32'(rsp_err), 32'(we && (a == 5'd0)));
`endif
    tick();
    chk({tag, "_valid_done"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_ready_again"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int wc;
    int beats;
    int cyc;
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'd0;
    rst = 1'b1; core_halted = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; dump_start = 1'b0; rsp_ready = 1'b0;
    tick(); tick();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_addr",  32'(rsp_addr), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rf_ra",     32'(rf_ra), 32'd0);
    chk("rst_rf_wa",     32'(rf_wa), 32'd0);
    chk("rst_rf_wd",     rf_wd, 32'd0);
    chk("rst_rf_we",     32'(rf_we), 32'd0);
    chk("rst_dump_busy", 32'(dump_busy), 32'd0);
    rst = 1'b0; core_halted = 1'b1;
    tick();

    // write then read back
    wc = we_cnt;
    xfer(1'b1, 5'd5, 32'hDEADBEEF, 32'h0, "wr5");
    chk("wr5_we_pulses", 32'(we_cnt - wc), 32'd1);
    chk("wr5_wa", 32'(last_wa), 32'd5);
    chk("wr5_wd", last_wd, 32'hDEADBEEF);
    xfer(1'b0, 5'd5, 32'h0, 32'hDEADBEEF, "rd5");

    // x0 write suppressed but acked
    wc = we_cnt;
    xfer(1'b1, 5'd0, 32'h12345678, 32'h0, "wr0");
    chk("wr0_we_pulses", 32'(we_cnt - wc), 32'd0);
    xfer(1'b0, 5'd0, 32'h0, 32'h0, "rd0");

    // backpressure
    rf_mem[7] = 32'hA5A5A5A5;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd7; rsp_ready = 1'b0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_addr",  32'(rsp_addr), 32'd7);
      chk("bp_rdata", rsp_rdata, 32'hA5A5A5A5);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      tick();
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    chk("bp_done", 32'(rsp_valid), 32'd0);

    // gating by core_halted
    wc = we_cnt;
    core_halted = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd9; req_wdata = 32'h99;
    #1 chk("gate_req_ready", 32'(req_ready), 32'd0);
    tick(); tick(); tick();
    chk("gate_no_rsp", 32'(rsp_valid), 32'd0);
    chk("gate_no_we", 32'(we_cnt - wc), 32'd0);
    req_valid = 1'b0; core_halted = 1'b1;
    tick();

    // dump, with a simultaneous write request that must lose
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'(i) * 32'h01010101;
    wc = we_cnt;
    dump_start = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd3; req_wdata = 32'hFFFFFFFF;
    #1 chk("prio_req_ready", 32'(req_ready), 32'd0);
    tick();
    dump_start = 1'b0; req_valid = 1'b0;
    chk("dump_busy_on", 32'(dump_busy), 32'd1);
    beats = 0; cyc = 0;
    while (beats < 32 && cyc < 600) begin
      rsp_ready = 1'($urandom_range(0, 1));
      #1;
      if (rsp_valid && rsp_ready) begin
        chk("dump_addr", 32'(rsp_addr), 32'(beats));
        chk("dump_data", rsp_rdata, 32'(beats) * 32'h01010101);
        beats++;
      end
      tick();
      cyc++;
    end
    rsp_ready = 1'b1;
    chk("dump_beats", 32'(beats), 32'd32);
    chk("dump_busy_off", 32'(dump_busy), 32'd0);
    chk("dump_no_rsp_after", 32'(rsp_valid), 32'd0);
    chk("prio_no_we", 32'(we_cnt - wc), 32'd0);
    tick();

    // reset while in WRITE
    wc = we_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd4; req_wdata = 32'h55;
    tick();
    req_valid = 1'b0; rst = 1'b1;
    #1 chk("rstw_we_gated", 32'(rf_we), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstw_rsp_addr",  32'(rsp_addr), 32'd0);
    chk("rstw_rf_wa",     32'(rf_wa), 32'd0);
    chk("rstw_rf_wd",     rf_wd, 32'd0);
    chk("rstw_rf_we",     32'(rf_we), 32'd0);
    chk("rstw_dump_busy", 32'(dump_busy), 32'd0);
    tick(); tick();
    chk("rstw_no_rsp", 32'(rsp_valid), 32'd0);
    chk("rstw_no_we", 32'(we_cnt - wc), 32'd0);
    xfer(1'b0, 5'd4, 32'h0, 32'h04040404, "rd4_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rf_debug_port.md
Name: rf_debug_port

Overview:
- Initiator-side access unit for the 32x32 register file (x0 hard-wired to zero).
- Accepts single read/write requests from a debug host over a valid/ready channel.
- Also runs a "dump" sequence that streams all 32 registers out.
- Drives one read address port and the write port (A3/WD/WE); top level muxes these against the core while core_halted=1.

Parameters:
- DATA_W, 32, register width.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- core_halted  in  1  core is stopped; debug access permitted.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid&ready.
- req_we  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  register index.
- req_wdata  in  DATA_W  write data.
- dump_start  in  1  single-cycle pulse; start full dump.
- dump_busy  out  1  dump sequence active.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  host accepts response.
- rsp_addr  out  ADDR_W  index the response refers to.
- rsp_rdata  out  DATA_W  read data (0 for write acks).
- rf_ra  out  ADDR_W  drives register file read address.
- rf_rd  in  DATA_W  combinational read data for rf_ra.
- rf_wa  out  ADDR_W  write address (A3).
- rf_wd  out  DATA_W  write data (WD).
- rf_we  out  1  write enable (WE).

Behaviour:
- Reset: state IDLE. All outputs 0: req_ready, rsp_valid, rsp_addr, rsp_rdata, rf_ra, rf_wa, rf_wd, rf_we, dump_busy. Dump counter = 0.
- The single clock and the synchronous active-high rst are decided; rst mid-operation aborts immediately. Any pending response is dropped and no write is issued on the following edge.
- req_ready = (state==IDLE) & core_halted & ~dump_start.
- FSM states: IDLE, READ, WRITE, RESP, DUMP_RD, DUMP_RSP.
- IDLE
  - dump_start & core_halted -> DUMP_RD, counter=0. dump_start has priority over a simultaneous req_valid.
  - Accepted read -> READ. Accepted write -> WRITE.
  - Address and data are latched at acceptance.
- READ (1 cycle)
  - rf_ra = latched addr; rf_rd is captured into rsp_rdata at the cycle end.
  - -> RESP.
- WRITE (1 cycle)
  - rf_wa/rf_wd = latched values.
  - rf_we=1, except rf_we=0 when addr==0 (x0 writes suppressed).
  - rsp_rdata=0 -> RESP.
- RESP: rsp_valid=1; rsp_addr/rsp_rdata held stable until rsp_ready, then -> IDLE.
- Latency: acceptance at edge N, rsp_valid at N+2. With rsp_ready held 1, the next request is accepted at N+3.
- rf_we is asserted in exactly one cycle per accepted write, never otherwise.
- DUMP_RD: rf_ra=counter; capture rf_rd and counter into the rsp regs -> DUMP_RSP.
- DUMP_RSP
  - rsp_valid=1 until rsp_ready.
  - Then: counter==2**ADDR_W-1 -> IDLE; else counter+1 -> DUMP_RD.
  - Counter never wraps.
- Dump output: a dump produces exactly 32 beats, addr 0..31 in order. Beat 0 carries rf_rd (0 from x0).
- dump_busy is 1 in DUMP_RD/DUMP_RSP.
- core_halted dropping mid-operation does not abort; the current op or dump completes. It only gates new acceptance.
- dump_start outside IDLE is ignored.

Optional Feature:
- Macro RF_DEBUG_PORT_ERR_EN.
- Defined:
  - Adds output rsp_err (1 bit, reset 0), valid with rsp_valid.
  - rsp_err=1 on the ack of a write to addr 0; 0 otherwise.
- Undefined: port absent; an x0 write is acked silently.
- rf_we suppression for x0 is identical in both builds.

Decomposition:
- Package rf_debug_pkg:
  - FSM state enum (6 states).
  - RF_DEPTH = 32.
  - Localparam for the last dump index.
- One natural sub-module: rf_debug_rsp_reg. It is the response holding register: load strobe, addr/data/err capture, rsp_valid/rsp_ready hold logic.
- The FSM and dump counter stay in rf_debug_port.

Test Plan:
- Write then read back: write addr 5, data 0xDEADBEEF with rsp_ready=1.
  - Expect rf_we=1 for one cycle with rf_wa=5, rf_wd=0xDEADBEEF.
  - Expect an ack rsp_rdata=0 at N+2.
  - Read addr 5 -> rsp_rdata=0xDEADBEEF, rsp_addr=5 at N+2.
- x0 write: write addr 0, data 0x12345678.
  - Expect rf_we never 1 and an ack returned.
  - With RF_DEBUG_PORT_ERR_EN, rsp_err=1.
  - Read addr 0 -> 0x00000000.
- Backpressure: read addr 7 (preloaded 0xA5A5A5A5), hold rsp_ready=0 for 5 cycles.
  - rsp_valid, rsp_addr=7 and rsp_rdata stay stable.
  - req_ready=0 throughout.
  - Transfer completes on the first cycle rsp_ready=1.
- Dump: preload reg i = i*0x01010101, pulse dump_start, randomise rsp_ready.
  - Exactly 32 beats, rsp_addr 0..31 in order, data matches (beat 0 = 0).
  - dump_busy falls after beat 31.
- Priority and gating:
  - dump_start and req_valid in the same cycle -> request not accepted, dump runs.
  - req_valid with core_halted=0 -> req_ready=0, no rf_we.
- Reset mid-operation: assert rst in the WRITE state.
  - All outputs 0 next cycle, no rf_we pulse, no response.
  - A subsequent read works normally.
